// File: rtl/step_to_angle.sv
// Decodes an asynchronous step/dir stream into a signed microstep position,
// measures the step period in microseconds and converts position to an angle.
//
// state  | meaning
// S_IDLE | angle_o valid, waiting for convert_i
// S_MULT | shift-add multiply, one multiplier bit per cycle, LSB first
// S_DONE | apply sign, publish angle_o, raise done_o
module step_to_angle #(
  parameter int              SIZE       = 64,
  parameter logic [SIZE-1:0] INV_SCALE  = SIZE'(64'd1046787),
  parameter int              SYSCLK     = 25000000,
  parameter int              TIMEOUT_US = 100000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            step_i,
  input  logic            dir_i,
  input  logic            clear_i,
  input  logic            convert_i,
  output logic            done_o,
  output logic [SIZE-1:0] angle_o,
  output logic [SIZE-1:0] position_o,
  output logic [31:0]     period_o,
  output logic            idle_o
);

  localparam int DIV = SYSCLK / 1000000;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(SIZE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic step_s1_q, step_s2_q, step_prev_q;
  logic dir_s1_q, dir_s2_q;
  logic step_edge;

  logic [SIZE-1:0] pos_q;
  logic [PW-1:0]   pre_q, pre_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     period_q;
  logic            idle_q;
  logic            tick;

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] mult_q, mult_d;
  logic [SIZE-1:0] scale_q, scale_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic [SIZE-1:0] angle_q, angle_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic            sign_q, sign_d;
  logic            done_q, done_d;
  logic [SIZE-1:0] pos_mag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_prev_q <= 1'b0;
      dir_s1_q    <= 1'b0;
      dir_s2_q    <= 1'b0;
    end else begin
      step_s1_q   <= step_i;
      step_s2_q   <= step_s1_q;
      step_prev_q <= step_s2_q;
      dir_s1_q    <= dir_i;
      dir_s2_q    <= dir_s1_q;
    end
  end

  assign step_edge = step_s2_q & ~step_prev_q;

  // clear has priority: a step edge in the same cycle is dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        pos_q <= '0;
    else if (clear_i)   pos_q <= '0;
    else if (step_edge) pos_q <= dir_s2_q ? pos_q + SIZE'(1) : pos_q - SIZE'(1);
  end

  always_comb begin
    tick  = (pre_q == PW'(DIV - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);
    cnt_d = (tick && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;
    if (step_edge) begin
      pre_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      idle_q   <= 1'b1;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      if (step_edge) begin
        period_q <= cnt_q;
        idle_q   <= 1'b0;
      end else if (cnt_d >= 32'(TIMEOUT_US)) begin
        idle_q <= 1'b1;
      end
    end
  end

  assign pos_mag = pos_q[SIZE-1] ? -pos_q : pos_q;

  always_comb begin
    state_d = state_q;
    mult_d  = mult_q;
    scale_d = scale_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    sign_d  = sign_q;
    angle_d = angle_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (convert_i) begin
          mult_d  = pos_mag;
          sign_d  = pos_q[SIZE-1];
          scale_d = INV_SCALE;
          acc_d   = '0;
          bit_d   = '0;
          done_d  = 1'b0;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        // scale_q holds INV_SCALE << bit_q; bits shifted past SIZE-1 are dropped
        if (mult_q[0]) acc_d = acc_q + scale_q;
        scale_d = scale_q << 1;
        mult_d  = mult_q >> 1;
        bit_d   = bit_q + CW'(1);
        if (bit_q == CW'(SIZE - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        angle_d = sign_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mult_q  <= '0;
      scale_q <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      sign_q  <= 1'b0;
      angle_q <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      mult_q  <= mult_d;
      scale_q <= scale_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      sign_q  <= sign_d;
      angle_q <= angle_d;
      done_q  <= done_d;
    end
  end

  assign done_o     = done_q;
  assign angle_o    = angle_q;
  assign position_o = pos_q;
  assign period_o   = period_q;
  assign idle_o     = idle_q;

endmodule

// File: tb/tb_step_to_angle.sv
// Self-checking bench for step_to_angle: step decoding, period/idle timing,
// and angle conversion checked against a scoreboard of modelled products.
module tb_step_to_angle;

  localparam int          SIZE   = 64;
  localparam logic [63:0] INV    = 64'd1046787;
  localparam int          SYSCLK = 25000000;
  localparam int          TOUT   = 200;
  localparam int          DIV    = SYSCLK / 1000000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            step = 1'b0, dir = 1'b0, clear = 1'b0, convert = 1'b0;
  logic            done_o, idle_o;
  logic [SIZE-1:0] angle_o, position_o;
  logic [31:0]     period_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [63:0] model_pos = 0;
  logic [63:0] exp_q[$];

  step_to_angle #(
    .SIZE(SIZE), .INV_SCALE(INV), .SYSCLK(SYSCLK), .TIMEOUT_US(TOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .step_i(step), .dir_i(dir), .clear_i(clear),
    .convert_i(convert), .done_o(done_o), .angle_o(angle_o),
    .position_o(position_o), .period_o(period_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] angle_model(input logic signed [63:0] p);
    logic [63:0] mag;
    mag = (p < 0) ? 64'(-p) : 64'(p);
    return (p < 0) ? -(mag * INV) : (mag * INV);
  endfunction

  task automatic step_pulse(input logic d, input int hi, input int lo);
    @(negedge clk);
    dir  = d;
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
    repeat (lo) @(negedge clk);
    model_pos += d ? 64'sd1 : -64'sd1;
  endtask

  task automatic run_convert(input string name, input bit poke);
    int lat;
    logic [63:0] exp;
    exp_q.push_back(angle_model(model_pos));
    @(negedge clk);
    convert = 1'b1;
    @(negedge clk);
    convert = 1'b0;
    lat = 0;
    while (done_o === 1'b0 && lat < 200) begin
      lat++;
      if (poke) convert = (lat == 5 || lat == 40 || lat == 65);
      @(negedge clk);
    end
    convert = 1'b0;
    n_checks++;
    if (lat != SIZE + 1) begin
      n_fail++;
      $display("FAIL %s latency: done_o low %0d cycles, expected %0d", name, lat, SIZE + 1);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (angle_o !== exp) begin
      n_fail++;
      $display("FAIL %s angle: angle_o=%h expected %h", name, angle_o, exp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_o !== 1'b1 || angle_o !== exp) begin
      n_fail++;
      $display("FAIL %s hold: done_o=%b angle_o=%h expected done 1 angle %h", name, done_o, angle_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_o !== 1'b1 || idle_o !== 1'b1 || angle_o !== '0 || position_o !== '0 || period_o !== '0) begin
      n_fail++;
      $display("FAIL reset: done=%b idle=%b angle=%h pos=%h period=%0d expected 1 1 0 0 0",
               done_o, idle_o, angle_o, position_o, period_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_forward();
    repeat (5) step_pulse(1'b1, 30, 30);
    n_checks++;
    if (position_o !== 64'(model_pos) || model_pos != 5) begin
      n_fail++;
      $display("FAIL forward pos: position_o=%0d expected 5", $signed(position_o));
    end
    n_checks++;
    if (period_o !== 32'd2) begin
      n_fail++;
      $display("FAIL forward period: period_o=%0d expected 2", period_o);
    end
    n_checks++;
    if (idle_o !== 1'b0) begin
      n_fail++;
      $display("FAIL forward idle: idle_o=%b expected 0", idle_o);
    end
  endtask

  task automatic test_reverse();
    repeat (8) step_pulse(1'b0, 3, 3);
    n_checks++;
    if (position_o !== 64'(model_pos) || model_pos != -3) begin
      n_fail++;
      $display("FAIL reverse pos: position_o=%0d expected -3", $signed(position_o));
    end
    run_convert("convert_neg3", 1'b0);
  endtask

  task automatic test_full_degree();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_pos = 0;
    n_checks++;
    if (position_o !== '0) begin
      n_fail++;
      $display("FAIL clear: position_o=%0d expected 0", $signed(position_o));
    end
    repeat (4103) step_pulse(1'b1, 3, 3);
    n_checks++;
    if (position_o !== 64'(model_pos)) begin
      n_fail++;
      $display("FAIL pos4103: position_o=%0d expected %0d", $signed(position_o), model_pos);
    end
    run_convert("convert_4103_pokes", 1'b1);
  endtask

  task automatic test_clear_collision();
    @(negedge clk);
    dir  = 1'b1;
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    model_pos = 0;
    n_checks++;
    if (position_o !== '0) begin
      n_fail++;
      $display("FAIL clear_collision: position_o=%0d expected 0", $signed(position_o));
    end
    step_pulse(1'b0, 3, 3);
    n_checks++;
    if (position_o !== 64'(model_pos)) begin
      n_fail++;
      $display("FAIL after_clear step: position_o=%0d expected %0d", $signed(position_o), model_pos);
    end
  endtask

  task automatic test_idle();
    int w, ic;
    step_pulse(1'b1, 30, 30);
    @(negedge clk);
    dir  = 1'b1;
    step = 1'b1;
    w = 0;
    while (position_o === 64'(model_pos) && w < 10) begin
      @(negedge clk);
      w++;
    end
    model_pos += 1;
    step = 1'b0;
    n_checks++;
    if (position_o !== 64'(model_pos)) begin
      n_fail++;
      $display("FAIL idle step pos: position_o=%0d expected %0d", $signed(position_o), model_pos);
    end
    n_checks++;
    if (period_o !== 32'd2) begin
      n_fail++;
      $display("FAIL idle pre period: period_o=%0d expected 2", period_o);
    end
    ic = 0;
    while (idle_o !== 1'b1 && ic < DIV * TOUT + 100) begin
      @(negedge clk);
      ic++;
    end
    n_checks++;
    if (ic != DIV * TOUT) begin
      n_fail++;
      $display("FAIL idle timing: idle_o rose after %0d cycles, expected %0d", ic, DIV * TOUT);
    end
    n_checks++;
    if (period_o !== 32'd2) begin
      n_fail++;
      $display("FAIL idle period hold: period_o=%0d expected 2", period_o);
    end
    step_pulse(1'b1, 3, 3);
    n_checks++;
    if (idle_o !== 1'b0 || position_o !== 64'(model_pos)) begin
      n_fail++;
      $display("FAIL idle wake: idle_o=%b pos=%0d expected 0 %0d", idle_o, $signed(position_o), model_pos);
    end
  endtask

  task automatic test_reset_mid_mult();
    @(negedge clk);
    convert = 1'b1;
    @(negedge clk);
    convert = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mult busy: done_o=%b expected 0", done_o);
    end
    rst_n = 1'b0;
    #1;
    model_pos = 0;
    n_checks++;
    if (done_o !== 1'b1 || angle_o !== '0 || position_o !== '0 || idle_o !== 1'b1 || period_o !== '0) begin
      n_fail++;
      $display("FAIL async reset: done=%b angle=%h pos=%h idle=%b period=%0d expected 1 0 0 1 0",
               done_o, angle_o, position_o, idle_o, period_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    step_pulse(1'b1, 3, 3);
    n_checks++;
    if (position_o !== 64'(model_pos)) begin
      n_fail++;
      $display("FAIL post reset step: position_o=%0d expected %0d", $signed(position_o), model_pos);
    end
    run_convert("convert_after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_full_degree();
    test_clear_collision();
    test_idle();
    test_reset_mid_mult();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
